// File: rtl/processor_pkg.sv
// Shared definitions for the processor memory subsystem.
//   arb_state_e  : memory arbiter FSM states (IDLE / WAIT_IF / WAIT_DM)
//   SIZE_*       : access-size codes on the memory request bus; the data
//                  memory decodes the same values.
package processor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data port.
// Only one transaction is ever outstanding. Data requests win by default,
// but once STARVE_LIMIT data grants in a row have gone by with fetch waiting,
// fetch takes the next grant.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req_* / if_rsp_*         fetch request handshake and response pulse
//   dm_req_* / dm_rsp_*         data request handshake (load/store) and response
//   mem_req_* / mem_* / mem_rsp_* forwarded request to memory and its response
//   err_spurious                sticky flag: response seen with nothing outstanding
module memory_arbiter
  import processor_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  dm_req_valid,
  output logic                  dm_req_ready,
  input  logic                  dm_req_we,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr,
  input  logic [DATA_WIDTH-1:0] dm_req_wdata,
  input  logic [1:0]            dm_req_size,
  input  logic                  dm_req_unsigned,
  output logic                  dm_rsp_valid,
  output logic [DATA_WIDTH-1:0] dm_rsp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_size,
  output logic                  mem_unsigned,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  err_spurious
);

  localparam int              CntW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  arb_state_e            state_q, state_d;
  logic [CntW-1:0]       starve_q, starve_d;
  logic                  dmStore_q, dmStore_d;
  logic                  err_q, err_d;
  logic                  ifRspValid_q, ifRspValid_d;
  logic                  dmRspValid_q, dmRspValid_d;
  logic [DATA_WIDTH-1:0] ifRspData_q, ifRspData_d;
  logic [DATA_WIDTH-1:0] dmRspData_q, dmRspData_d;
  logic                  ifWins;
  logic                  anyReq;

  // Fetch only beats a pending data request once the starvation counter
  // has saturated.
  assign ifWins = if_req_valid && (!dm_req_valid || (starve_q == CntMax));
  assign anyReq = if_req_valid || dm_req_valid;

  // Next-state, request mux and response capture. The request path is
  // purely combinational in IDLE so a ready memory accepts the same cycle.
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    dmStore_d     = dmStore_q;
    err_d         = err_q;
    ifRspValid_d  = 1'b0;
    dmRspValid_d  = 1'b0;
    ifRspData_d   = ifRspData_q;
    dmRspData_d   = dmRspData_q;
    if_req_ready  = 1'b0;
    dm_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_size      = SIZE_WORD;
    mem_unsigned  = 1'b0;

    case (state_q)
      IDLE: begin
        mem_req_valid = anyReq;
        if (ifWins) begin
          mem_addr = if_req_addr;
        end else begin
          mem_we       = dm_req_we;
          mem_addr     = dm_req_addr;
          mem_wdata    = dm_req_wdata;
          mem_size     = dm_req_size;
          mem_unsigned = dm_req_unsigned;
        end

        if (anyReq && mem_req_ready) begin
          if (ifWins) begin
            if_req_ready = 1'b1;
            state_d      = WAIT_IF;
            starve_d     = '0;
          end else begin
            dm_req_ready = 1'b1;
            state_d      = WAIT_DM;
            dmStore_d    = dm_req_we;
            // Count only grants that actually made fetch wait.
            if (!if_req_valid) begin
              starve_d = '0;
            end else if (starve_q != CntMax) begin
              starve_d = starve_q + CntW'(1);
            end
          end
        end

        // A response with nothing outstanding is dropped but remembered.
        if (mem_rsp_valid) begin
          err_d = 1'b1;
        end
      end

      WAIT_IF: begin
        if (mem_rsp_valid) begin
          ifRspValid_d = 1'b1;
          ifRspData_d  = mem_rsp_data;
          state_d      = IDLE;
        end
      end

      WAIT_DM: begin
        if (mem_rsp_valid) begin
          dmRspValid_d = 1'b1;
          dmRspData_d  = dmStore_q ? '0 : mem_rsp_data;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers; reset abandons any outstanding
  // transaction since the memory is reset alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      dmStore_q    <= 1'b0;
      err_q        <= 1'b0;
      ifRspValid_q <= 1'b0;
      dmRspValid_q <= 1'b0;
      ifRspData_q  <= '0;
      dmRspData_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      dmStore_q    <= dmStore_d;
      err_q        <= err_d;
      ifRspValid_q <= ifRspValid_d;
      dmRspValid_q <= dmRspValid_d;
      ifRspData_q  <= ifRspData_d;
      dmRspData_q  <= dmRspData_d;
    end
  end

  assign if_rsp_valid = ifRspValid_q;
  assign if_rsp_data  = ifRspData_q;
  assign dm_rsp_valid = dmRspValid_q;
  assign dm_rsp_data  = dmRspData_q;
  assign err_spurious = err_q;

endmodule
